seq_detect_moore_param: RTL and testbench

Parametrised Moore-type serial sequence detector, the successor to the fixed 4-bit 1010 detector. It compares a 1-bit serial stream `go` against a compile-time pattern of configurable length. Overlapping or non-overlapping detection is selected at run time, and input bits are qualified by an enable. It also keeps a saturating match counter. It sits directly on the serial data path and drives a registered, glitch-free `get` flag for downstream control logic.

---
 rtl/seq_det_pkg.sv | 67 ++++++
 rtl/sat_counter.sv | 25 ++
 rtl/seq_detect_moore_param.sv | 59 +++++
 tb/tb_seq_detect_moore_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Purpose: shared constants and KMP next-progress function for the serial pattern detector.
// Latency: n/a (package; pure combinational function).
// Backpressure: n/a.
package seq_det_pkg;

    // Largest supported pattern and the progress width it needs.
    localparam int PAT_W_MAX = 16;
    localparam int K_W_MAX   = $clog2(PAT_W_MAX + 1);

    // Progress value that means "nothing matched yet".
    localparam int ST_IDLE = 0;

    // Width of a progress register able to hold 0..pat_w.
    function automatic int prog_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Next progress value after sampling bit b from progress k.
    // pat holds the pattern in its low pat_w bits, MSB expected first.
    // The candidate stream is the first k pattern bits followed by b; the
    // result is the longest pattern prefix that is a suffix of it. When k is
    // the full pattern and ovl=0 the history is discarded, which is the same
    // as starting over from k=0.
    // Loops run over fixed bounds so the function maps to plain logic.
    function automatic logic [K_W_MAX-1:0] next_progress(
        input logic [PAT_W_MAX-1:0] pat,
        input int                   pat_w,
        input logic [K_W_MAX-1:0]   k,
        input logic                 b,
        input logic                 ovl
    );
        logic [PAT_W_MAX:0] s;
        logic [3:0]         pidx;
        logic [4:0]         sidx;
        logic               ok;
        int                 kk;
        int                 best;

        kk = (int'(k) == pat_w && !ovl) ? 0 : int'(k);

        s = '0;
        for (int j = 0; j < PAT_W_MAX; j++) begin
            if (j < kk) begin
                pidx = 4'(pat_w - 1 - j);
                s[5'(j)] = pat[pidx];
            end
        end
        s[5'(kk)] = b;

        best = 0;
        for (int l = 1; l <= PAT_W_MAX; l++) begin
            if (l <= kk + 1 && l <= pat_w) begin
                ok = 1'b1;
                for (int i = 0; i < PAT_W_MAX; i++) begin
                    if (i < l) begin
                        pidx = 4'(pat_w - 1 - i);
                        sidx = 5'(kk + 1 - l + i);
                        if (pat[pidx] != s[sidx]) ok = 1'b0;
                    end
                end
                if (ok) best = l;
            end
        end
        return K_W_MAX'(best);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter that saturates at all-ones, with synchronous clear.
// Latency: q reflects inc/clr one cycle after the sampling edge.
// Backpressure: none; clr wins over inc on the same edge.
//   ports: clk, rst_n (async active-low), inc, clr, q[W-1:0]
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_moore_param.sv
// Purpose: Moore serial detector for a parameterised pattern, KMP fallback, run-time overlap select, saturating match count.
// Latency: get/match_cnt valid the cycle after the edge that samples the last pattern bit.
// Backpressure: none; en=0 freezes all state, one bit per clock otherwise.
//   ports: clk, rst_n, go (serial bit), en (bit valid), ovl (overlap mode),
//          cnt_clr (sync counter clear), get (registered match flag), match_cnt
module seq_detect_moore_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             en,
    input  logic             ovl,
    input  logic             cnt_clr,
    output logic             get,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                   PW       = prog_w(PAT_W);
    localparam logic [PW-1:0]        K_IDLE   = PW'(ST_IDLE);
    localparam logic [PW-1:0]        K_MATCH  = PW'(PAT_W);
    localparam logic [PAT_W_MAX-1:0] PAT_EXT  = PAT_W_MAX'(PATTERN);

    logic [PW-1:0] state;
    logic [PW-1:0] nxt;
    logic          hit;

    always_comb begin
        nxt = PW'(next_progress(PAT_EXT, PAT_W, K_W_MAX'(state), go, ovl));
        hit = en && (nxt == K_MATCH);
    end

    // get is its own flop, loaded with the decoded next state, so it is a
    // clean register output with no path from go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= K_IDLE;
            get   <= 1'b0;
        end else if (en) begin
            state <= nxt;
            get   <= (nxt == K_MATCH);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit),
        .clr   (cnt_clr),
        .q     (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_moore_param.sv
module tb_seq_detect_moore_param;

    logic       clk;
    logic       rst_n;
    logic       go;
    logic       en;
    logic       ovl;
    logic       cnt_clr;

    logic       get_a, get_b, get_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int n_checks = 0;
    int n_pass   = 0;

    // a: default 1010 / 8-bit count, b: 111 / 8-bit, c: 1010 / 2-bit count
    seq_detect_moore_param u_dut_a (
        .clk(clk), .rst_n(rst_n), .go(go), .en(en), .ovl(ovl),
        .cnt_clr(cnt_clr), .get(get_a), .match_cnt(cnt_a)
    );

    seq_detect_moore_param #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .go(go), .en(en), .ovl(ovl),
        .cnt_clr(cnt_clr), .get(get_b), .match_cnt(cnt_b)
    );

    seq_detect_moore_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .go(go), .en(en), .ovl(ovl),
        .cnt_clr(cnt_clr), .get(get_c), .match_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    typedef struct {
        logic       rst;    // pulse reset before this vector
        logic [1:0] sel;    // which instance to check: 0=a, 1=b
        logic       ovl;
        logic       go;
        logic       exp_get;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [1:0] s, input logic o,
                                input logic g, input logic eg, input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.sel = s; v.ovl = o; v.go = g; v.exp_get = eg; v.exp_cnt = ec;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, then land 1 ns after the edge for sampling.
    task automatic step(input logic g, input logic e, input logic c);
        go = g; en = e; cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; go = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_c(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
    endtask

    initial begin
        logic [11:0] s1;
        logic [5:0]  s2;
        logic [11:0] g1;
        logic [5:0]  g2o, g2n;
        logic [7:0]  c_exp;
        logic        act_get;
        logic [7:0]  act_cnt;

        rst_n = 1'b1; go = 1'b0; en = 1'b0; ovl = 1'b0; cnt_clr = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_get_a", {31'b0, get_a}, 32'd0);
        chk("reset_cnt_a", {24'b0, cnt_a}, 32'd0);
        chk("reset_get_b", {31'b0, get_b}, 32'd0);
        chk("reset_cnt_c", {30'b0, cnt_c}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stream 0,0,1,0,1,1,0,1,0,1,1,0 (first bit in MSB), ovl=0: match after bit 9.
        s1 = 12'b0010_1101_0110;
        g1 = 12'b0000_0000_1000;
        for (int i = 0; i < 12; i++) begin
            c_exp = (i >= 8) ? 8'd1 : 8'd0;
            add(i == 0, 2'd0, 1'b0, s1[11-i], g1[11-i], c_exp);
        end

        // 1,0,1,0,1,0 with ovl=1 (pulses after 4 and 6) and ovl=0 (after 4 only).
        s2  = 6'b101010;
        g2o = 6'b000101;
        g2n = 6'b000100;
        for (int i = 0; i < 6; i++)
            add(i == 0, 2'd0, 1'b1, s2[5-i], g2o[5-i], (i >= 5) ? 8'd2 : (i >= 3) ? 8'd1 : 8'd0);
        for (int i = 0; i < 6; i++)
            add(i == 0, 2'd0, 1'b0, s2[5-i], g2n[5-i], (i >= 3) ? 8'd1 : 8'd0);

        // Pattern 111, ovl=1, five ones: get high after bits 3,4,5.
        for (int i = 0; i < 5; i++)
            add(i == 0, 2'd1, 1'b1, 1'b1, (i >= 2), (i >= 2) ? 8'(i - 1) : 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            ovl = tbl[i].ovl;
            step(tbl[i].go, 1'b1, 1'b0);
            act_get = (tbl[i].sel == 2'd1) ? get_b : get_a;
            act_cnt = (tbl[i].sel == 2'd1) ? cnt_b : cnt_a;
            chk($sformatf("tbl%0d_get", i), {31'b0, act_get}, {31'b0, tbl[i].exp_get});
            chk($sformatf("tbl%0d_cnt", i), {24'b0, act_cnt}, {24'b0, tbl[i].exp_cnt});
        end

        // Enable gaps: disabled cycles with random go must not disturb progress,
        // and a held MATCH keeps get high.
        do_reset();
        ovl = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            chk("en_gap_get", {31'b0, get_a}, 32'd0);
        end
        step(1'b1, 1'b1, 1'b0);
        chk("en_bit3_get", {31'b0, get_a}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("en_match_get", {31'b0, get_a}, 32'd1);
        chk("en_match_cnt", {24'b0, cnt_a}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            chk("en_hold_get", {31'b0, get_a}, 32'd1);
            chk("en_hold_cnt", {24'b0, cnt_a}, 32'd1);
        end
        step(1'b0, 1'b1, 1'b0);
        chk("en_after_get", {31'b0, get_a}, 32'd0);
        chk("en_after_cnt", {24'b0, cnt_a}, 32'd1);

        // 2-bit counter saturation, then clear colliding with a match.
        do_reset();
        ovl = 1'b0;
        for (int m = 0; m < 5; m++) begin
            send_c(4'b1010);
            chk($sformatf("sat_cnt%0d", m), {30'b0, cnt_c}, (m < 3) ? 32'(m + 1) : 32'd3);
            chk("sat_get", {31'b0, get_c}, 32'd1);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("clr_cnt", {30'b0, cnt_c}, 32'd0);
        chk("clr_get", {31'b0, get_c}, 32'd1);
        cnt_clr = 1'b0;

        // Asynchronous reset in mid-cycle discards progress and count.
        do_reset();
        ovl = 1'b0;
        send_c(4'b1010);
        chk("ar_pre_cnt", {24'b0, cnt_a}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_get", {31'b0, get_a}, 32'd0);
        chk("ar_cnt", {24'b0, cnt_a}, 32'd0);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        chk("ar_no_match", {31'b0, get_a}, 32'd0);
        send_c(4'b1010);
        chk("ar_rematch_get", {31'b0, get_a}, 32'd1);
        chk("ar_rematch_cnt", {24'b0, cnt_a}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
